mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 29 ++
 rtl/mem_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: CPU-side strobes/data and bus-side request/response signals
// of the memory controller, bundled as one interface.
// master: the controller itself. slave: the CPU/bus environment around it.
interface mem_ctrl_if;
    logic        ram_read;
    logic        ram_write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        mem_busy;
    logic        mem_ready;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        input  ram_read, ram_write, addr, wdata, bus_rdata, bus_ack,
        output rdata, mem_busy, mem_ready, bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );

    modport slave (
        output ram_read, ram_write, addr, wdata, bus_rdata, bus_ack,
        input  rdata, mem_busy, mem_ready, bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding CPU-to-bus memory controller.
// Reads wait for bus_ack and return data with a one-cycle mem_ready pulse;
// writes are posted and complete silently on bus_ack.
// Optional feature macro: MEM_CTRL_TIMEOUT_EN adds a bus-ack timeout of
// TIMEOUT_CYC cycles with a sticky bus_err flag. Without it the controller
// waits forever and bus_err is tied low.
module mem_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        READY   = 2'd3
    } state_t;

    // The timeout limit must fit the 8-bit counter and be nonzero.
    if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("mem_ctrl: TIMEOUT_CYC must be in 1..255");
    end

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic [7:0] cnt_inc;
    logic       timeout;

    // Timeout fires on the wait cycle where the count would reach the limit.
    always_comb begin
        cnt_inc = cnt_q + 8'd1;
        timeout = (cnt_inc == TO_LIM);
    end
`endif

    // Next-state logic: accept one strobe in IDLE, then wait for ack (or timeout).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MEM_CTRL_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                // Write has priority when both strobes arrive together.
                if (bus.ram_write) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    state_d = WR_WAIT;
`ifdef MEM_CTRL_TIMEOUT_EN
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
`endif
                end else if (bus.ram_read) begin
                    addr_d  = bus.addr;
                    state_d = RD_WAIT;
`ifdef MEM_CTRL_TIMEOUT_EN
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
`endif
                end
            end
            RD_WAIT: begin
                if (bus.bus_ack) begin
                    rdata_d = bus.bus_rdata;
                    state_d = READY;
`ifdef MEM_CTRL_TIMEOUT_EN
                end else if (timeout) begin
                    rdata_d = 16'hFFFF;
                    err_d   = 1'b1;
                    state_d = READY;
                end else begin
                    cnt_d   = cnt_inc;
`endif
                end
            end
            WR_WAIT: begin
                if (bus.bus_ack) begin
                    state_d = IDLE;
`ifdef MEM_CTRL_TIMEOUT_EN
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_inc;
`endif
                end
            end
            READY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched transfer registers; reset aborts any transfer at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_CTRL_TIMEOUT_EN
    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.bus_err = err_q;
`else
    assign bus.bus_err = 1'b0;
`endif

    // All handshake outputs decode from registers only.
    assign bus.mem_busy  = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    assign bus.bus_req   = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    assign bus.bus_we    = (state_q == WR_WAIT);
    assign bus.mem_ready = (state_q == READY);
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl. Stimulus pushes the expected
// bus request and read result of each transaction into queues; a monitor
// pops and compares whenever the DUT raises bus_req or mem_ready.
module tb_mem_ctrl;

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO = 4;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          len;
    } req_t;

    logic clk;
    logic rst_n;
    mem_ctrl_if bif();

    mem_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int n_pass = 0;
    int n_total = 0;

    req_t        exp_req[$];
    logic [15:0] exp_rd[$];

    int ack_delay = 0;
    bit spur = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s actual=present required=absent at %0t", name, $time);
    endtask

    // Bus slave: acks on wait cycle ack_delay+1; outside a request drives spur.
    initial begin
        int wcnt;
        wcnt = 0;
        bif.bus_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bif.bus_req === 1'b1) begin
                bif.bus_ack = (wcnt == ack_delay);
                wcnt++;
            end else begin
                bif.bus_ack = spur;
                wcnt = 0;
            end
        end
    end

    // Monitor: checks each bus request and each read completion against the queues.
    initial begin
        req_t        cur;
        bit          in_req, cur_ok, prev_rdy;
        int          len;
        logic [15:0] last_rd, e;
        in_req = 0; cur_ok = 0; prev_rdy = 0; len = 0; last_rd = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                exp_req.delete();
                exp_rd.delete();
                in_req = 0; cur_ok = 0; prev_rdy = 0; last_rd = 16'h0000;
            end else begin
                if (bif.bus_req === 1'b1) begin
                    if (!in_req) begin
                        in_req = 1; len = 0;
                        if (exp_req.size() == 0) begin
                            fail("unexpected_req");
                            cur_ok = 0;
                        end else begin
                            cur = exp_req.pop_front();
                            cur_ok = 1;
                        end
                    end
                    if (cur_ok) begin
                        chk("req_we", bif.bus_we, cur.we);
                        chk("req_addr", bif.bus_addr, cur.addr);
                        if (cur.we) chk("req_wdata", bif.bus_wdata, cur.wdata);
                    end
                    len++;
                end else if (in_req) begin
                    in_req = 0;
                    if (cur_ok) chk("req_len", len, cur.len);
                end
                if (bif.mem_ready === 1'b1) begin
                    if (prev_rdy) fail("ready_two_cycles");
                    if (exp_rd.size() == 0) begin
                        fail("unexpected_ready");
                    end else begin
                        e = exp_rd.pop_front();
                        chk("rdata", bif.rdata, e);
                        last_rd = e;
                    end
                end else begin
                    chk("rdata_hold", bif.rdata, last_rd);
                end
                prev_rdy = (bif.mem_ready === 1'b1);
            end
        end
    end

    // kind: 0 read, 1 write, 2 both strobes. noise pulses strobes during the wait.
    task automatic do_txn(input int kind, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] rd, input int dly, input bit noise, input bit spur_i);
        req_t r;
        bit   to, done;
        int   len, c, busy_n, rdy_n;
        to  = TO_EN && (dly >= TO);
        len = to ? TO : dly + 1;
        @(posedge clk); #1;
        ack_delay = dly;
        spur = spur_i;
        bif.bus_rdata = rd;
        bif.addr = a;
        bif.wdata = d;
        bif.ram_write = (kind != 0);
        bif.ram_read = (kind != 1);
        r.we = (kind != 0); r.addr = a; r.wdata = d; r.len = len;
        exp_req.push_back(r);
        if (kind == 0) exp_rd.push_back(to ? 16'hFFFF : rd);
        rst_n = 1'b1;
        c = 0; busy_n = 0; rdy_n = 0; done = 0;
        while (!done && c < 400) begin
            @(posedge clk); #1;
            c++;
            if (c == 1) begin
                bif.ram_read = noise;
                bif.ram_write = noise & 1'($urandom_range(0, 1));
                chk("err_cleared", bif.bus_err, 0);
            end else begin
                bif.ram_read = 1'b0;
                bif.ram_write = 1'b0;
            end
            if (bif.mem_busy === 1'b1) busy_n++;
            if (bif.mem_ready === 1'b1) rdy_n++;
            if (c >= 2 && bif.mem_busy === 1'b0 && bif.mem_ready === 1'b0) done = 1;
        end
        chk("txn_done", done, 1);
        chk("busy_len", busy_n, len);
        chk("ready_cnt", rdy_n, (kind == 0) ? 1 : 0);
        chk("done_at", c, (kind == 0) ? len + 2 : len + 1);
        chk("err_flag", bif.bus_err, to);
    endtask

    initial begin
        bif.ram_read = 1'b0; bif.ram_write = 1'b0;
        bif.addr = 16'h0000; bif.wdata = 16'h0000; bif.bus_rdata = 16'h0000;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", bif.mem_busy, 0);
        chk("rst_ready", bif.mem_ready, 0);
        chk("rst_req", bif.bus_req, 0);
        chk("rst_we", bif.bus_we, 0);
        chk("rst_err", bif.bus_err, 0);
        chk("rst_rdata", bif.rdata, 0);
        chk("rst_addr", bif.bus_addr, 0);
        chk("rst_wdata", bif.bus_wdata, 0);
        repeat (2) @(posedge clk);

        // Directed: minimum-latency read, delayed write, both strobes, spurious ack.
        do_txn(0, 16'h1234, 16'h0000, 16'hBEEF, 0, 1'b0, 1'b0);
        do_txn(1, 16'h0040, 16'hA5A5, 16'h0000, 3, 1'b0, 1'b0);
        do_txn(2, 16'h0777, 16'h5A5A, 16'h1111, 1, 1'b1, 1'b0);
        do_txn(0, 16'h2222, 16'h0000, 16'hC0DE, 2, 1'b1, 1'b1);
        do_txn(1, 16'h3333, 16'h4444, 16'h0000, 0, 1'b0, 1'b1);

        // Reset in the middle of a read.
        @(posedge clk); #1;
        spur = 1'b0;
        ack_delay = 255;
        bif.addr = 16'h0BAD;
        bif.ram_read = 1'b1;
        begin
            req_t r;
            r.we = 1'b0; r.addr = 16'h0BAD; r.wdata = 16'h0000; r.len = 0;
            exp_req.push_back(r);
            exp_rd.push_back(16'h0000);
        end
        @(posedge clk); #1;
        bif.ram_read = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_req", bif.bus_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", bif.bus_req, 0);
        chk("midrst_busy", bif.mem_busy, 0);
        chk("midrst_addr", bif.bus_addr, 0);
        repeat (2) @(posedge clk);
        do_txn(0, 16'h5678, 16'h0000, 16'h9ABC, 1, 1'b0, 1'b0);

        if (TO_EN) begin
            // Timed-out read, error stays sticky while idle, ack on the limit cycle wins.
            do_txn(0, 16'h0F0F, 16'h0000, 16'h1357, 255, 1'b0, 1'b0);
            repeat (3) @(posedge clk);
            #1 chk("err_sticky", bif.bus_err, 1);
            do_txn(1, 16'h0A0A, 16'hFACE, 16'h0000, TO - 1, 1'b0, 1'b0);
            do_txn(1, 16'h0B0B, 16'hCAFE, 16'h0000, 255, 1'b0, 1'b0);
            do_txn(0, 16'h0C0C, 16'h0000, 16'h2468, TO - 1, 1'b0, 1'b0);
        end

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            do_txn(int'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        chk("req_queue_empty", exp_req.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
